// File: rtl/ni_out_buffer_mvc.sv
// Multi-VC NI output buffer: one flit FIFO per virtual channel, packet-atomic
// round-robin arbitration and per-VC credit flow control toward the switch.
module ni_out_buffer_mvc #(
  parameter int FLIT_WIDTH = 80,
  parameter int NUM_VC     = 2,
  parameter int VCW        = 1,
  parameter int DEPTH      = 6,
  parameter int LOG_DEPTH  = 3,
  parameter int CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic                  tail_in,
  input  logic [VCW-1:0]        write_vc,
  input  logic                  write,
  output logic [NUM_VC-1:0]     full,
  output logic [FLIT_WIDTH-1:0] FLIT_out,
  output logic                  VALID_out,
  output logic [VCW-1:0]        VC_out,
  output logic                  TAIL_out,
  input  logic [NUM_VC-1:0]     CREDIT_in
);

  localparam int                   EW        = FLIT_WIDTH + 1;
  localparam logic [3:0]           CRED_INIT = 4'(CREDITS);
  localparam logic [LOG_DEPTH-1:0] DEPTH_L   = LOG_DEPTH'(DEPTH);
  localparam logic [LOG_DEPTH-1:0] LAST_L    = LOG_DEPTH'(DEPTH - 1);

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  // Per-VC storage: entry = {tail, flit}
  logic [EW-1:0]         r_mem   [NUM_VC][DEPTH];
  logic [LOG_DEPTH-1:0]  r_wptr  [NUM_VC];
  logic [LOG_DEPTH-1:0]  r_rptr  [NUM_VC];
  logic [LOG_DEPTH-1:0]  r_count [NUM_VC];
  logic [3:0]            r_credit[NUM_VC];

  arb_state_t            r_arb_state;
  arb_state_t            w_arb_next;
  logic [VCW-1:0]        r_lock_vc;
  logic [VCW-1:0]        w_lock_vc_next;
  logic [VCW-1:0]        r_rr_ptr;
  logic [VCW-1:0]        w_rr_next;

  logic [FLIT_WIDTH-1:0] r_flit_out;
  logic                  r_valid_out;
  logic [VCW-1:0]        r_vc_out;
  logic                  r_tail_out;

  logic [NUM_VC-1:0]     w_push;
  logic [NUM_VC-1:0]     w_pop;
  logic [NUM_VC-1:0]     w_elig;
  logic [NUM_VC-1:0]     w_ret;
  logic [NUM_VC-1:0]     w_cred_full;
  logic                  w_grant;
  logic [VCW-1:0]        w_gvc;
  logic [EW-1:0]         w_head;

  assign FLIT_out  = r_flit_out;
  assign VALID_out = r_valid_out;
  assign VC_out    = r_vc_out;
  assign TAIL_out  = r_tail_out;

  // Arbitration works only on registered state, so a flit written this cycle
  // can never be granted before the next edge.
  always_comb begin
    logic [VCW-1:0] idx;
    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_grant = 1'b0;
    w_gvc   = '0;
    idx     = '0;
    if (r_arb_state == ARB_LOCKED) begin
      w_gvc   = r_lock_vc;
      w_grant = w_elig[r_lock_vc];
    end else begin
      for (int i = 1; i <= NUM_VC; i++) begin
        idx = VCW'((int'(r_rr_ptr) + i) % NUM_VC);
        if (!w_grant && w_elig[idx]) begin
          w_grant = 1'b1;
          w_gvc   = idx;
        end
      end
    end
  end

  assign w_head = r_mem[w_gvc][r_rptr[w_gvc]];

  always_comb begin
    w_push      = '0;
    w_pop       = '0;
    w_elig      = '0;
    w_ret       = '0;
    w_cred_full = '0;
    full        = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]        = (r_count[v] == DEPTH_L);
      w_elig[v]      = (r_count[v] != '0) && (r_credit[v] != '0);
      w_cred_full[v] = (r_credit[v] == CRED_INIT);
      // Returns beyond the initial allowance are bogus and dropped.
      w_ret[v]       = CREDIT_in[v] && !w_cred_full[v];
      // write_vc values beyond NUM_VC-1 match no v and are dropped here.
      w_push[v]      = write && (int'(write_vc) == v) && !full[v];
      w_pop[v]       = w_grant && (int'(w_gvc) == v);
    end
  end

  // Packet-lock FSM: a non-tail grant pins the link to that VC until its tail.
  always_comb begin
    w_arb_next     = r_arb_state;
    w_lock_vc_next = r_lock_vc;
    w_rr_next      = r_rr_ptr;
    if (w_grant) begin
      if (w_head[FLIT_WIDTH]) begin
        w_arb_next = ARB_OPEN;
        w_rr_next  = w_gvc;
      end else begin
        w_arb_next     = ARB_LOCKED;
        w_lock_vc_next = w_gvc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arb_state <= ARB_OPEN;
      r_lock_vc   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_arb_state <= w_arb_next;
      r_lock_vc   <= w_lock_vc_next;
      r_rr_ptr    <= w_rr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wptr[v]   <= '0;
        r_rptr[v]   <= '0;
        r_count[v]  <= '0;
        r_credit[v] <= CRED_INIT;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_push[v]) r_wptr[v] <= (r_wptr[v] == LAST_L) ? '0 : r_wptr[v] + 1'b1;
        if (w_pop[v])  r_rptr[v] <= (r_rptr[v] == LAST_L) ? '0 : r_rptr[v] + 1'b1;
        case ({w_push[v], w_pop[v]})
          2'b10:   r_count[v] <= r_count[v] + 1'b1;
          2'b01:   r_count[v] <= r_count[v] - 1'b1;
          default: r_count[v] <= r_count[v];
        endcase
        case ({w_ret[v], w_pop[v]})
          2'b10:   r_credit[v] <= r_credit[v] + 1'b1;
          2'b01:   r_credit[v] <= r_credit[v] - 1'b1;
          default: r_credit[v] <= r_credit[v];
        endcase
      end
    end
  end

  // NOTE: the flit array has no reset; the pointers and counts reset instead,
  // which makes any stale entry unreachable.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_push[v]) r_mem[v][r_wptr[v]] <= {tail_in, data_in};
    end
  end

  // Link register: flit fields hold their last value while no grant occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flit_out  <= '0;
      r_valid_out <= 1'b0;
      r_vc_out    <= '0;
      r_tail_out  <= 1'b0;
    end else begin
      r_valid_out <= w_grant;
      if (w_grant) begin
        r_flit_out <= w_head[FLIT_WIDTH-1:0];
        r_vc_out   <= w_gvc;
        r_tail_out <= w_head[FLIT_WIDTH];
      end
    end
  end

  a_credit_overflow: assert property (
    @(posedge clk) disable iff (rst) (CREDIT_in & w_cred_full) == '0
  );

endmodule

// File: tb/tb_ni_out_buffer_mvc.sv
// Bench for ni_out_buffer_mvc: directed scenarios plus random traffic, each
// cycle compared against a queue-based model of the buffer's rules.
module tb_ni_out_buffer_mvc;

  localparam int FW        = 80;
  localparam int NV        = 2;
  localparam int VCW       = 1;
  localparam int DEPTH     = 6;
  localparam int LOG_DEPTH = 3;
  localparam int CREDITS   = 4;

  typedef struct packed {
    logic          tail;
    logic [FW-1:0] data;
  } flit_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] data_in = '0;
  logic          tail_in = 1'b0;
  logic [VCW-1:0] write_vc = '0;
  logic          write = 1'b0;
  logic [NV-1:0] full;
  logic [FW-1:0] FLIT_out;
  logic          VALID_out;
  logic [VCW-1:0] VC_out;
  logic          TAIL_out;
  logic [NV-1:0] CREDIT_in = '0;

  ni_out_buffer_mvc #(
    .FLIT_WIDTH(FW), .NUM_VC(NV), .VCW(VCW), .DEPTH(DEPTH),
    .LOG_DEPTH(LOG_DEPTH), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .tail_in(tail_in),
    .write_vc(write_vc), .write(write), .full(full), .FLIT_out(FLIT_out),
    .VALID_out(VALID_out), .VC_out(VC_out), .TAIL_out(TAIL_out),
    .CREDIT_in(CREDIT_in)
  );

  always #5 clk = ~clk;

  // Reference model state
  flit_t         m_q[NV][$];
  int            m_cred[NV];
  bit            m_locked;
  int            m_lock_vc;
  int            m_rr;
  logic          m_valid;
  logic [FW-1:0] m_flit;
  int            m_vc;
  logic          m_tail;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid_seen = 0;
  int n_tail_seen = 0;
  int obs_vc[$];

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_flit();
    return {16'($urandom()), 32'($urandom()), 32'($urandom())};
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_q[v].delete();
      m_cred[v] = CREDITS;
    end
    m_locked  = 1'b0;
    m_lock_vc = 0;
    m_rr      = 0;
    m_valid   = 1'b0;
    m_flit    = '0;
    m_vc      = 0;
    m_tail    = 1'b0;
  endfunction

  // One clock edge of the buffer's rules, decided from the pre-edge state.
  function automatic void model_edge(input bit wr, input int vc, input logic [FW-1:0] d,
                                     input bit tl, input logic [NV-1:0] cr);
    bit    full_pre[NV];
    int    cred_pre[NV];
    int    g;
    flit_t f;
    g = -1;
    for (int v = 0; v < NV; v++) begin
      full_pre[v] = (m_q[v].size() == DEPTH);
      cred_pre[v] = m_cred[v];
    end
    // An unfinished packet owns the link; otherwise the next ready VC after
    // the one that last finished a packet goes.
    if (m_locked) begin
      if (m_q[m_lock_vc].size() > 0 && m_cred[m_lock_vc] > 0) g = m_lock_vc;
    end else begin
      for (int i = 1; i <= NV; i++) begin
        int v = (m_rr + i) % NV;
        if (g < 0 && m_q[v].size() > 0 && m_cred[v] > 0) g = v;
      end
    end
    m_valid = 1'b0;
    if (g >= 0) begin
      f = m_q[g].pop_front();
      m_valid = 1'b1;
      m_flit  = f.data;
      m_vc    = g;
      m_tail  = f.tail;
      m_cred[g]--;
      if (f.tail) begin
        m_locked = 1'b0;
        m_rr     = g;
      end else begin
        m_locked  = 1'b1;
        m_lock_vc = g;
      end
    end
    if (wr && vc < NV && !full_pre[vc]) m_q[vc].push_back(flit_t'({tl, d}));
    for (int v = 0; v < NV; v++)
      if (cr[v] && cred_pre[v] < CREDITS) m_cred[v]++;
  endfunction

  task automatic compare_outputs();
    logic [NV-1:0] ef;
    for (int v = 0; v < NV; v++) ef[v] = (m_q[v].size() == DEPTH);
    check("valid", FW'(VALID_out), FW'(m_valid));
    check("flit",  FLIT_out, m_flit);
    check("vc",    FW'(VC_out), FW'(m_vc));
    check("tail",  FW'(TAIL_out), FW'(m_tail));
    check("full",  FW'(full), FW'(ef));
    if (VALID_out === 1'b1) begin
      n_valid_seen++;
      if (TAIL_out === 1'b1) n_tail_seen++;
      obs_vc.push_back(int'(VC_out));
    end
  endtask

  task automatic step(input bit wr, input int vc, input bit tl, input logic [NV-1:0] cr);
    logic [FW-1:0] d;
    d         = rand_flit();
    data_in   = d;
    write     = wr;
    write_vc  = VCW'(vc);
    tail_in   = tl;
    CREDIT_in = cr;
    @(posedge clk);
    model_edge(wr, vc, d, tl, cr);
    #1;
    write     = 1'b0;
    tail_in   = 1'b0;
    CREDIT_in = '0;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, '0);
  endtask

  // Return credits only where the model shows some outstanding.
  task automatic restore_credits();
    logic [NV-1:0] cr;
    for (int k = 0; k < CREDITS + 1; k++) begin
      for (int v = 0; v < NV; v++) cr[v] = (m_cred[v] < CREDITS);
      step(1'b0, 0, 1'b0, cr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_ord[4];
    logic [NV-1:0] cr;
    exp_ord = '{0, 0, 1, 1};

    #1;
    do_reset();

    // 3-flit packet on VC0: no bypass, three consecutive flits, tail on last.
    n_valid_seen = 0; n_tail_seen = 0;
    step(1'b1, 0, 1'b0, '0);
    check("t1_no_bypass", FW'(VALID_out), FW'(1'b0));
    step(1'b1, 0, 1'b0, '0);
    check("t1_first_out", FW'(VALID_out), FW'(1'b1));
    step(1'b1, 0, 1'b1, '0);
    idle(3);
    check("t1_valid_count", FW'(n_valid_seen), FW'(3));
    check("t1_tail_count", FW'(n_tail_seen), FW'(1));

    // Drain VC0's last credit, then overfill VC0 while it cannot send.
    step(1'b1, 0, 1'b0, '0);
    idle(1);
    n_valid_seen = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 0, (i == 5), '0);
    check("t3_full_after_6", FW'(full[0]), FW'(1'b1));
    check("t3_nothing_sent", FW'(n_valid_seen), FW'(0));
    step(1'b1, 0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b0, 2'b01);
    idle(2);
    check("t3_emitted", FW'(n_valid_seen), FW'(6));
    restore_credits();

    // Credit exhaustion on VC1 with a long unterminated packet.
    n_valid_seen = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1, 1'b0, '0);
    idle(3);
    check("t2_sent_on_credits", FW'(n_valid_seen), FW'(CREDITS));
    check("t2_never_full", FW'(full[1]), FW'(1'b0));
    step(1'b0, 0, 1'b0, 2'b10);
    check("t2_not_same_cycle", FW'(VALID_out), FW'(1'b0));
    idle(1);
    check("t2_fifth_after_credit", FW'({VALID_out, VC_out}), FW'({1'b1, 1'b1}));
    step(1'b0, 0, 1'b0, 2'b10);
    idle(1);

    // VC1 is locked without credit; VC0 waits even though it is eligible.
    step(1'b1, 0, 1'b0, '0);
    step(1'b1, 0, 1'b1, '0);
    step(1'b1, 1, 1'b1, '0);
    n_valid_seen = 0;
    idle(4);
    check("t5_link_stalled", FW'(n_valid_seen), FW'(0));
    step(1'b0, 0, 1'b0, 2'b10);
    idle(1);
    check("t5_vc1_resumes", FW'({VALID_out, VC_out, TAIL_out}), FW'({1'b1, 1'b1, 1'b1}));
    idle(3);
    restore_credits();

    // Two concurrent 2-flit packets, two rounds.
    for (int r = 0; r < 2; r++) begin
      obs_vc.delete();
      step(1'b1, 0, 1'b0, '0);
      step(1'b1, 1, 1'b0, '0);
      step(1'b1, 0, 1'b1, '0);
      step(1'b1, 1, 1'b1, '0);
      idle(4);
      check($sformatf("t4_r%0d_count", r), FW'(obs_vc.size()), FW'(4));
      for (int i = 0; i < 4; i++)
        check($sformatf("t4_r%0d_order%0d", r, i),
              FW'((i < obs_vc.size()) ? obs_vc[i] : -1), FW'(exp_ord[i]));
    end
    restore_credits();

    // Reset with flits queued and a packet locked.
    step(1'b1, 0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1, 1'b0, '0);
    idle(1);
    do_reset();
    check("t6_flit_cleared", FLIT_out, '0);
    n_valid_seen = 0;
    idle(4);
    check("t6_no_stale", FW'(n_valid_seen), FW'(0));
    for (int i = 0; i < 6; i++) step(1'b1, 1, 1'b0, '0);
    idle(3);
    check("t6_full_credits", FW'(n_valid_seen), FW'(CREDITS));

    // Random traffic with one reset in the middle.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int v = 0; v < NV; v++)
        cr[v] = (m_cred[v] < CREDITS) && ($urandom_range(0, 99) < 35);
      step(($urandom_range(0, 99) < 60), $urandom_range(0, NV - 1),
           ($urandom_range(0, 2) == 0), cr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
